// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// The zero-divisor shortcut is enabled by defining DIVIDER_ZERO_DETECT_EN.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // Accepting edge to done: PREP, DIV_WIDTH iterations, FIX.
    localparam int LATENCY = DIV_WIDTH + 2;

    // Zero divisor with detection enabled: PREP then FIX, so done is in the
    // third cycle counting the accepting one.
    localparam int ZERO_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } state_t;

endpackage

// File: rtl/seq_signed_divider_if.sv
// Start/done handshake and operand/result bus of the sequential signed divider.
interface seq_signed_divider_if #(
    parameter int WIDTH = div_pkg::DIV_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
// Relies on the divisor magnitude never exceeding 2^(WIDTH-1), so the shifted value fits in WIDTH bits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             msb_in,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // NOTE: every output is assigned on every path through this block, so no latch is inferred.
    always_comb begin
        shifted = {rem_in, msb_in};
        trial   = shifted - {1'b0, dvsr};
        q_bit   = ~trial[WIDTH];
        rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: one quotient bit per clock on magnitudes, sign fix-up at the end.
// Define DIVIDER_ZERO_DETECT_EN to short-circuit a zero divisor and raise div_by_zero.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_signed_divider_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] qacc;
    logic [WIDTH-1:0] bmag;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    // qacc starts as the dividend magnitude and fills with quotient bits from the LSB.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .msb_in  (qacc[WIDTH-1]),
        .dvsr    (bmag),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

`ifndef DIVIDER_ZERO_DETECT_EN
    assign bus.div_by_zero = 1'b0;
`endif

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            a_lat         <= '0;
            b_lat         <= '0;
            rem           <= '0;
            qacc          <= '0;
            bmag          <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
`ifdef DIVIDER_ZERO_DETECT_EN
            bus.div_by_zero <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_lat    <= bus.dividend;
                        b_lat    <= bus.divisor;
                        bus.busy <= 1'b1;
                        state    <= PREP;
                    end
                end
                PREP: begin
                    sign_q <= a_lat[WIDTH-1] ^ b_lat[WIDTH-1];
                    sign_r <= a_lat[WIDTH-1];
                    // Negating -2^(WIDTH-1) yields itself, which read unsigned is the right magnitude.
                    qacc   <= a_lat[WIDTH-1] ? -a_lat : a_lat;
                    bmag   <= b_lat[WIDTH-1] ? -b_lat : b_lat;
                    rem    <= '0;
                    cnt    <= '0;
`ifdef DIVIDER_ZERO_DETECT_EN
                    state  <= (b_lat == '0) ? FIX : ITER;
`else
                    state  <= ITER;
`endif
                end
                ITER: begin
                    rem  <= rem_next;
                    qacc <= {qacc[WIDTH-2:0], q_bit};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
`ifdef DIVIDER_ZERO_DETECT_EN
                    if (b_lat == '0) begin
                        bus.quotient    <= '1;
                        bus.remainder   <= a_lat;
                        bus.div_by_zero <= 1'b1;
                    end else begin
                        bus.quotient    <= sign_q ? -qacc : qacc;
                        bus.remainder   <= sign_r ? -rem : rem;
                        bus.div_by_zero <= 1'b0;
                    end
`else
                    bus.quotient  <= sign_q ? -qacc : qacc;
                    bus.remainder <= sign_r ? -rem : rem;
`endif
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider against a C-semantics arithmetic model.
// Build with DIVIDER_ZERO_DETECT_EN defined to exercise the zero-divisor shortcut.
module tb_seq_signed_divider;
    import div_pkg::*;

    localparam int W     = DIV_WIDTH;
    localparam int LIMIT = LATENCY + 20;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_signed_divider_if #(.WIDTH(W)) bus ();

    seq_signed_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Truncating division with dividend-signed remainder, done in 64-bit plain arithmetic.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint la, lb;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        q  = W'(la / lb);
        r  = W'(la % lb);
    endfunction

    // Issues one operation (DUT must be idle) and waits for done; lat = -1 on timeout.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output logic busy_ok);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        lat = -1; busy_ok = 1'b1; q = '0; r = '0; z = 1'b0;
        for (int k = 1; k <= LIMIT; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = k;
                q   = bus.quotient;
                r   = bus.remainder;
                z   = bus.div_by_zero;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
                break;
            end else if (bus.busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.quotient !== '0) begin
            n_fail++; $display("FAIL reset_quotient: got %h expected 0", bus.quotient);
        end
        n_checks++;
        if (bus.remainder !== '0) begin
            n_fail++; $display("FAIL reset_remainder: got %h expected 0", bus.remainder);
        end
        n_checks++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got busy/done/dbz %b expected 000",
                               {bus.busy, bus.done, bus.div_by_zero});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int ta[7] = '{14, -7,  7, -10, 32'h80000000, 32'h80000000, -79815};
        int tb[7] = '{ 7,  2, -2,  -5, -1,           1,            313};
        int tq[7] = '{ 2, -3, -3,   2, 32'h80000000, 32'h80000000, -255};
        int tr[7] = '{ 0, -1,  1,   0, 0,            0,            0};
        int lat; logic [W-1:0] q, r; logic z, bok;
        for (int i = 0; i < 7; i++) begin
            do_op(W'(ta[i]), W'(tb[i]), lat, q, r, z, bok);
            n_checks++;
            if (lat != LATENCY) begin
                n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LATENCY);
            end
            n_checks++;
            if (q !== W'(tq[i])) begin
                n_fail++; $display("FAIL directed_quotient[%0d]: got %h expected %h", i, q, W'(tq[i]));
            end
            n_checks++;
            if (r !== W'(tr[i])) begin
                n_fail++; $display("FAIL directed_remainder[%0d]: got %h expected %h", i, r, W'(tr[i]));
            end
            n_checks++;
            if (z !== 1'b0) begin
                n_fail++; $display("FAIL directed_dbz[%0d]: got %b expected 0", i, z);
            end
            n_checks++;
            if (bok !== 1'b1) begin
                n_fail++; $display("FAIL directed_busy[%0d]: busy not high until done or not low in done cycle", i);
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [W-1:0] a, b, q, r, eq, er; logic z, bok;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if (i % 9 == 0) a = 32'h80000000;
            case ($urandom_range(0, 2))
                0:       b = $urandom;
                1:       b = W'($urandom_range(1, 20));
                default: b = W'($urandom_range(1, 65535));
            endcase
            if ($urandom_range(0, 1) == 1) b = -b;
            if (b == '0) b = 1;
            ref_div(a, b, eq, er);
            do_op(a, b, lat, q, r, z, bok);
            n_checks++;
            if (q !== eq || r !== er || lat != LATENCY) begin
                n_fail++;
                $display("FAIL random[%0d] %h/%h: got q=%h r=%h lat=%0d expected q=%h r=%h lat=%0d",
                         i, a, b, q, r, lat, eq, er, LATENCY);
            end
            n_checks++;
            if (W'(q * b + r) !== a) begin
                n_fail++; $display("FAIL random_identity[%0d]: q*b+r=%h expected %h", i, W'(q * b + r), a);
            end
        end
    endtask

    task automatic test_zero();
        int lat; logic [W-1:0] q, r; logic z, bok;
        do_op(W'(5), '0, lat, q, r, z, bok);
`ifdef DIVIDER_ZERO_DETECT_EN
        n_checks++;
        if (q !== '1 || r !== W'(5)) begin
            n_fail++; $display("FAIL zero_result: got q=%h r=%h expected q=ffffffff r=5", q, r);
        end
        n_checks++;
        if (z !== 1'b1) begin
            n_fail++; $display("FAIL zero_flag: got %b expected 1", z);
        end
        n_checks++;
        if (lat != ZERO_LATENCY) begin
            n_fail++; $display("FAIL zero_latency: got %0d expected %0d", lat, ZERO_LATENCY);
        end
`else
        n_checks++;
        if (z !== 1'b0) begin
            n_fail++; $display("FAIL zero_flag: got %b expected 0", z);
        end
        n_checks++;
        if (lat != LATENCY) begin
            n_fail++; $display("FAIL zero_latency: got %0d expected %0d", lat, LATENCY);
        end
`endif
    endtask

    task automatic test_ignore_start_and_reset();
        int dones, lat; logic [W-1:0] q, r, eq, er; logic z, bok;
        ref_div(W'(1000), W'(-7), eq, er);
        bus.start = 1'b1; bus.dividend = W'(1000); bus.divisor = W'(-7);
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones = 0; lat = -1; q = '0; r = '0;
        for (int k = 1; k <= LIMIT + 10; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                dones++;
                if (lat < 0) begin lat = k; q = bus.quotient; r = bus.remainder; end
            end
            if (k == 9) begin
                bus.start = 1'b1; bus.dividend = W'(55); bus.divisor = W'(5);
            end else begin
                bus.start = 1'b0;
            end
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++; $display("FAIL ignore_start_dones: got %0d expected 1", dones);
        end
        n_checks++;
        if (q !== eq || r !== er || lat != LATENCY) begin
            n_fail++; $display("FAIL ignore_start_result: got q=%h r=%h lat=%0d expected q=%h r=%h lat=%0d",
                               q, r, lat, eq, er, LATENCY);
        end

        bus.start = 1'b1; bus.dividend = $urandom; bus.divisor = W'(3);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.quotient !== '0 || bus.remainder !== '0) begin
            n_fail++; $display("FAIL midop_reset_outputs: got q=%h r=%h expected 0 0", bus.quotient, bus.remainder);
        end
        n_checks++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            n_fail++; $display("FAIL midop_reset_flags: got %b expected 000", {bus.busy, bus.done, bus.div_by_zero});
        end
        @(posedge clk); #1 reset = 1'b0;
        dones = 0;
        for (int k = 0; k < LIMIT; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++; $display("FAIL midop_reset_done: got %0d done pulses expected 0", dones);
        end

        do_op(W'(-79815), W'(313), lat, q, r, z, bok);
        n_checks++;
        if (q !== W'(-255) || r !== '0 || lat != LATENCY) begin
            n_fail++; $display("FAIL after_reset_result: got q=%h r=%h lat=%0d expected q=%h r=0 lat=%0d",
                               q, r, lat, W'(-255), LATENCY);
        end
    endtask

    task automatic test_roundtrip();
        int lat; logic [W-1:0] a, b, p, q, r; logic z, bok;
        a = 32'hFFFFFF01;
        b = W'(313);
        p = a * b;
        do_op(p, b, lat, q, r, z, bok);
        n_checks++;
        if (q !== a || r !== '0) begin
            n_fail++; $display("FAIL roundtrip_fixed: got q=%h r=%h expected q=%h r=0", q, r, a);
        end
        for (int i = 0; i < 10; i++) begin
            a = W'($signed(16'($urandom)));
            b = W'($signed(15'($urandom)));
            if (b == '0) b = W'(-1);
            p = a * b;
            do_op(p, b, lat, q, r, z, bok);
            n_checks++;
            if (q !== a || r !== '0) begin
                n_fail++; $display("FAIL roundtrip[%0d] %h*%h: got q=%h r=%h expected q=%h r=0", i, a, b, q, r, a);
            end
        end
    endtask

    // Each op starts in the done cycle of the previous one; a refused start would time out.
    task automatic test_back_to_back();
        int lat; logic [W-1:0] a, b, q, r, eq, er; logic z, bok;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = W'($urandom_range(1, 1000));
            if (i[0]) b = -b;
            ref_div(a, b, eq, er);
            do_op(a, b, lat, q, r, z, bok);
            n_checks++;
            if (q !== eq || r !== er || lat != LATENCY || bok !== 1'b1) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got q=%h r=%h lat=%0d busy_ok=%b expected q=%h r=%h lat=%0d busy_ok=1",
                         i, q, r, lat, bok, eq, er, LATENCY);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_zero();
        test_ignore_start_and_reset();
        test_roundtrip();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
